// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: single-entry val/rdy router stage that steers one held message to its
// destination lane, dropping messages with a bad destination or that stall past a timeout.
module demux_route_ctrl #(
    parameter int p_nbits    = 32,
    parameter int p_noutputs = 4,
    parameter int p_timeout  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    input  logic [p_nbits-1:0]             recv_msg,
    output logic [p_noutputs-1:0]          send_val,
    input  logic [p_noutputs-1:0]          send_rdy,
    output logic [p_noutputs*p_nbits-1:0]  send_msg,
    output logic [15:0]                    drop_count,
    output logic                           busy
);

    localparam int AW = $clog2(p_noutputs);
    localparam int TW = (p_timeout > 1) ? $clog2(p_timeout) : 1;
    localparam logic [TW-1:0] TLAST = TW'((p_timeout > 0) ? p_timeout - 1 : 0);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] msg_q, msg_d;
    logic [AW-1:0]      sel_q, sel_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [15:0]        drop_q, drop_d;
    logic [AW-1:0]      sel;
    logic               sel_ok;
    logic               hold;
    logic               fire;
    logic               rdy_int;
    logic               accept;
    logic               timeout;
    logic               drop_inc;

    assign sel     = recv_msg[p_nbits-1 -: AW];
    assign hold    = (state_q == HOLD);
    assign fire    = hold & send_rdy[sel_q];
    assign rdy_int = ~hold | fire;
    assign accept  = recv_val & rdy_int;
    assign timeout = hold & ~fire & (p_timeout != 0) & (timer_q == TLAST);

    // Destinations past the last lane only exist when the lane count is not a power of two.
    if (p_noutputs == (1 << AW)) begin : g_pow2
        assign sel_ok = 1'b1;
    end else begin : g_npow2
        assign sel_ok = {1'b0, sel} < (AW+1)'(p_noutputs);
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        drop_inc = 1'b0;
        if (hold && !fire) begin
            timer_d = timer_q + 1'b1;
            if (timeout) begin
                state_d  = IDLE;
                drop_inc = 1'b1;
            end
        end
        if (fire) state_d = IDLE;
        if (accept) begin
            if (sel_ok) begin
                msg_d   = recv_msg;
                sel_d   = sel;
                timer_d = '0;
                state_d = HOLD;
            end else begin
                state_d  = IDLE;
                drop_inc = 1'b1;
            end
        end
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            sel_q   <= '0;
            timer_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of register contents.
    always_comb begin
        send_val = '0;
        send_msg = '0;
        for (int i = 0; i < p_noutputs; i++) begin
            if (reset && hold && sel_q == AW'(i)) begin
                send_val[i]                     = 1'b1;
                send_msg[i*p_nbits +: p_nbits]  = msg_q;
            end
        end
    end

    assign recv_rdy   = reset & rdy_int;
    assign busy       = reset & hold;
    assign drop_count = reset ? drop_q : 16'd0;

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Single-entry routing controller for the router's output demux.
- Accepts one val/rdy message stream, decodes the destination from the message's top bits and holds the message in a register.
- Drives exactly one output lane with val/rdy, and zeroes every other lane.
- Drops messages that have an invalid destination or that stall past a timeout, and keeps a count of drops.

Parameters:
- p_nbits, 32: message width in bits; must be ≥ AW+1.
- p_noutputs, 4: number of output lanes, ≥2. AW = $clog2(p_noutputs).
- p_timeout, 16: maximum number of cycles a held message may wait on send_rdy; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: state clears at a rising edge of clk when reset==0.
- recv_val  in  1  input message valid.
- recv_rdy  out  1  input ready.
- recv_msg  in  p_nbits  input message; destination sel = recv_msg[p_nbits-1 -: AW].
- send_val  out  p_noutputs  per-lane valid; at most one bit is high.
- send_rdy  in  p_noutputs  per-lane ready.
- send_msg  out  p_noutputs*p_nbits  lane i occupies bits [i*p_nbits +: p_nbits]; it carries the held message when lane i is selected, otherwise 0.
- drop_count  out  16  count of dropped messages; saturates at 0xFFFF.
- busy  out  1  high when state==HOLD.

Behaviour:
- States: IDLE (no message held) and HOLD (message held). Registers: msg_q, sel_q, timer, drop_count.
- Reset: while reset==0, every output is combinationally forced low (recv_rdy, send_val, send_msg, busy); drop_count reads 0. At the next edge: state=IDLE, msg_q=0, sel_q=0, timer=0, drop_count=0.
- Reset in HOLD: the held message is discarded silently and drop_count is NOT incremented.
- Accept: accept = recv_val & recv_rdy.
- Accept with invalid sel (sel ≥ p_noutputs, only possible when p_noutputs is not a power of two): the message is dropped, drop_count is incremented, and the next state is IDLE.
- Accept with valid sel: msg_q←recv_msg, sel_q←sel, timer←0, next state HOLD.
- IDLE: recv_rdy=1; send_val=0; send_msg=0.
- HOLD outputs: send_val[sel_q]=1; lane sel_q of send_msg = msg_q; all other lanes are 0. send_rdy on unselected lanes is ignored.
- HOLD transfer: fire = send_rdy[sel_q]. In a fire cycle, recv_rdy=1 combinationally, so a new message can be accepted in the same cycle (full throughput, one message per cycle).
  - fire without accept: next state IDLE.
  - fire with accept: the new message is handled by the accept rules above.
- HOLD stall, no fire:
  - recv_rdy=0; timer increments.
  - Timeout (p_timeout≠0): if timer==p_timeout-1 this cycle, next state IDLE and drop_count is incremented. The message is therefore visible on send_val for exactly p_timeout cycles.
  - Fire in the timeout cycle wins: the transfer completes and nothing is dropped.
- Latency: one cycle from accept to send_val. Data order is preserved.
- recv_rdy never depends combinationally on recv_val, except through the fire path, which does not depend on recv_val.
- drop_count increments at most once per cycle and holds at 0xFFFF.
- send_val and send_msg depend only on registers; there is no combinational path from recv to send.

Test Plan (p_nbits=8, p_noutputs=4, p_timeout=4 unless noted):
1. Basic route: send 0x85 (addr 2) with send_rdy=4'b1111. Required: send_val=4'b0100 on the next cycle; lane 2=0x85; lanes 0, 1, 3 = 0; then IDLE.
2. Back-to-back: stream 0x05, 0x45, 0xC5 with send_rdy all high and recv_val held high. Required: recv_rdy stays 1; send_val is 0001, 0010, 1000 on consecutive cycles; no bubbles.
3. Backpressure and timeout: send 0x40 with send_rdy=0. Required: send_val=0010 for exactly 4 cycles, recv_rdy=0 throughout, then IDLE and drop_count=1. Repeat with send_rdy[1] raised in the 4th cycle: the transfer completes and drop_count is unchanged.
4. Invalid address (p_noutputs=3): send 0xC1. Required: send_val stays 000 and drop_count=1 on the next cycle. Then send 0x81: it routes to lane 2.
5. Reset mid-operation: hold 0x85 stalled, assert reset=0 for one cycle. Required: all outputs low during reset; afterwards IDLE, recv_rdy=1, drop_count=0.
6. Unselected ready: hold 0x85 with send_rdy=4'b1011 (only lane 2 low). Required: no transfer and the message remains held until timeout; drop_count saturation is checked by forcing 70000 timeouts and confirming drop_count holds at 0xFFFF.
